// File: rtl/qr_frame_buffer_pkg.sv
// qr_frame_buffer shared definitions:
// default geometry, width helper and read-pipeline tag.
package qr_pkg;

  localparam int DEF_DATA_W     = 48;
  localparam int DEF_FRAME_LEN  = 20;
  localparam int DEF_NUM_FRAMES = 10;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = cnt_w(DEF_FRAME_LEN);
  localparam int DEF_FRM_W = cnt_w(DEF_NUM_FRAMES);

  typedef struct packed {
    logic vld;
    logic bank;
    logic frm_last;
    logic batch_last;
  } rd_tag_t;

endpackage

// File: rtl/qr_frame_buffer_if.sv
// qr_frame_buffer sample bus: write strobe in,
// valid/ready frame stream and status out.
interface qr_fb_if
  import qr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
);

  logic              i_trig;
  logic [DATA_W-1:0] i_data;
  logic              i_rdy;
  logic              o_vld;
  logic [DATA_W-1:0] o_data;
  logic [IDX_W-1:0]  o_idx;
  logic              o_frm_last;
  logic              o_batch_last;
  logic              o_full;
  logic              o_ovf;

  modport master (
    output i_trig, i_data, i_rdy,
    input  o_vld, o_data, o_idx,
    input  o_frm_last, o_batch_last,
    input  o_full, o_ovf
  );

  modport slave (
    input  i_trig, i_data, i_rdy,
    output o_vld, o_data, o_idx,
    output o_frm_last, o_batch_last,
    output o_full, o_ovf
  );

endinterface

// File: rtl/qr_frame_buffer_bank.sv
// One frame of sample storage: one write port,
// one registered read port, contents never reset.
module qr_fb_bank
  import qr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FRAME_LEN,
  parameter int AW     = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/qr_frame_buffer.sv
// Ping-pong frame buffer: fills one bank while the
// other streams out through a two-stage read pipe.
module qr_frame_buffer
  import qr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  qr_fb_if.slave bus
);

  localparam int IDX_W = cnt_w(FRAME_LEN);
  localparam int FRM_W = cnt_w(NUM_FRAMES);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [FRM_W-1:0] LAST_FRM =
    FRM_W'(NUM_FRAMES - 1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  logic              wr_bank;
  logic [IDX_W-1:0]  wr_cnt;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_cnt;
  logic [FRM_W-1:0]  frm_cnt;
  logic [1:0]        full;
  logic [1:0]        full_nxt;

  rd_tag_t           s1;
  rd_tag_t           s1_nxt;
  logic [IDX_W-1:0]  s1_idx;
  logic [DATA_W-1:0] q [2];

  logic wr_fire;
  logic wr_last;
  logic rd_fire;
  logic rd_last;
  logic out_en;
  logic s1_en;

  // A bank frees once its last word enters the read
  // pipe, so a steady stream never sees both banks full.
  always_comb begin
    out_en  = !bus.o_vld || bus.i_rdy;
    s1_en   = !s1.vld || out_en;
    wr_fire = bus.i_trig && !bus.o_full;
    wr_last = wr_fire && (wr_cnt == LAST_IDX);
    rd_fire = s1_en && full[rd_bank];
    rd_last = rd_fire && (rd_cnt == LAST_IDX);
    for (int b = 0; b < 2; b++) begin
      full_nxt[b] = full[b];
      if (rd_last && rd_bank == 1'(b))
        full_nxt[b] = 1'b0;
      if (wr_last && wr_bank == 1'(b))
        full_nxt[b] = 1'b1;
    end
    s1_nxt            = '0;
    s1_nxt.vld        = rd_fire;
    s1_nxt.bank       = rd_bank;
    s1_nxt.frm_last   = rd_last;
    s1_nxt.batch_last = rd_last
                        && (frm_cnt == LAST_FRM);
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    qr_fb_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (FRAME_LEN),
      .AW     (IDX_W)
    ) u_bank (
      .clk     (i_clk),
      .wr_en   (wr_fire && wr_bank == 1'(g)),
      .wr_addr (wr_cnt),
      .wr_data (bus.i_data),
      .rd_en   (rd_fire && rd_bank == 1'(g)),
      .rd_addr (rd_cnt),
      .rd_data (q[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      frm_cnt    <= '0;
      full       <= '0;
      bus.o_full <= 1'b0;
      bus.o_ovf  <= 1'b0;
    end else begin
      full       <= full_nxt;
      bus.o_full <= &full_nxt;
      if (bus.i_trig && bus.o_full)
        bus.o_ovf <= 1'b1;
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + IDX_ONE;
        if (wr_last) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + IDX_ONE;
        if (rd_last) begin
          rd_bank <= !rd_bank;
          frm_cnt <= (frm_cnt == LAST_FRM)
                     ? '0 : frm_cnt + FRM_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1               <= '0;
      s1_idx           <= '0;
      bus.o_vld        <= 1'b0;
      bus.o_data       <= '0;
      bus.o_idx        <= '0;
      bus.o_frm_last   <= 1'b0;
      bus.o_batch_last <= 1'b0;
    end else begin
      if (s1_en) begin
        s1     <= s1_nxt;
        s1_idx <= rd_cnt;
      end
      if (out_en) begin
        bus.o_vld        <= s1.vld;
        bus.o_frm_last   <= s1.frm_last;
        bus.o_batch_last <= s1.batch_last;
        if (s1.vld) begin
          bus.o_data <= q[s1.bank];
          bus.o_idx  <= s1_idx;
        end
      end
    end
  end

endmodule
